i2c_target_regfile: RTL and testbench



---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_bus_cond.sv | 48 ++++
 rtl/i2c_target_regfile.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
// Holds the FSM state encoding, ACK/NAK line levels and a clog2 helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_MACK,
    IGNORE
  } i2c_state_e;

  // SDA line levels seen during an acknowledge slot
  localparam logic ACK_BIT = 1'b0;
  localparam logic NAK_BIT = 1'b1;

  localparam logic [6:0] GENERAL_CALL = 7'h00;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA input conditioning: multi-flop synchronisers followed by
// single-cycle pulses for SCL edges and START/STOP conditions.
module i2c_bus_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: sub-addressed writes and reads,
// repeated START, pointer auto-increment with wrap, NAK on bad sub-addresses.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h70,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00,
  localparam int        PTR_W       = clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic                  busy
);

  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REGS - 1);
  localparam logic [8:0]       NUM_REGS_W = 9'(NUM_REGS);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_cond #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_state_e       state_q,     state_d;
  logic [2:0]       bit_cnt_q,   bit_cnt_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       rd_byte_q,   rd_byte_d;
  logic [PTR_W-1:0] ptr_q,       ptr_d;
  logic             ack_hi_q,    ack_hi_d;
  logic             rw_q,        rw_d;
  logic             sda_oe_q,    sda_oe_d;
  logic             busy_q,      busy_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;

  logic [7:0]       regs_q [NUM_REGS];
  logic             reg_we;
  logic [7:0]       reg_wdata;

  logic [7:0]       shift_in;
  logic [PTR_W-1:0] ptr_inc;
  logic [7:0]       cur_reg;

  assign shift_in = {shift_q[6:0], sda_s};
  assign ptr_inc  = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
  assign cur_reg  = regs_q[ptr_q];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rd_byte_d   = rd_byte_q;
    ptr_d       = ptr_q;
    ack_hi_d    = ack_hi_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    reg_we      = 1'b0;
    reg_wdata   = shift_in;

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      ack_hi_d  = 1'b0;
    end else if (start_det) begin
      // Repeated START keeps the pointer so a sub-address write can precede a read
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
      ack_hi_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_q[6:0] == I2C_ADDR && I2C_ADDR != GENERAL_CALL) begin
                state_d  = ADDR_ACK;
                rw_d     = sda_s;
                busy_d   = 1'b1;
                ack_hi_d = 1'b0;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        SUB: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if ({1'b0, shift_in} < NUM_REGS_W) begin
                ptr_d    = shift_in[PTR_W-1:0];
                state_d  = SUB_ACK;
                ack_hi_d = 1'b0;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              reg_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_ptr_d    = ptr_q;
              ptr_d       = ptr_inc;
              state_d     = WR_ACK;
              ack_hi_d    = 1'b0;
            end
          end
        end

        // First falling edge starts the ACK, the one after the ACK clock ends it
        ADDR_ACK, SUB_ACK, WR_ACK: begin
          if (scl_rise) begin
            ack_hi_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_hi_q) begin
              sda_oe_d = ~ACK_BIT;
            end else begin
              ack_hi_d  = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ADDR_ACK && !rw_q) begin
                state_d = SUB;
              end else if (state_q == ADDR_ACK) begin
                state_d   = RD_BYTE;
                rd_byte_d = cur_reg;
                sda_oe_d  = ~cur_reg[7];
                ptr_d     = ptr_inc;
              end else begin
                state_d = WR_BYTE;
              end
            end
          end
        end

        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d  = RD_MACK;
              ack_hi_d = 1'b0;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~rd_byte_q[3'd7 - bit_cnt_q];
          end
        end

        RD_MACK: begin
          if (scl_rise) begin
            if (sda_s == NAK_BIT) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              ack_hi_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (!ack_hi_q) begin
              sda_oe_d = 1'b0;
            end else begin
              ack_hi_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = RD_BYTE;
              rd_byte_d = cur_reg;
              sda_oe_d  = ~cur_reg[7];
              ptr_d     = ptr_inc;
            end
          end
        end

        default: begin
          // IDLE and IGNORE only leave on START/STOP
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rd_byte_q   <= '0;
      ptr_q       <= '0;
      ack_hi_q    <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rd_byte_q   <= rd_byte_d;
      ptr_q       <= ptr_d;
      ack_hi_q    <= ack_hi_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (reg_we) begin
      regs_q[ptr_q] <= reg_wdata;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_flat[8*gi +: 8] = regs_q[gi];
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_ptr    = wr_ptr_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bus-master bench for i2c_target_regfile: drives SCL/SDA transactions and
// checks SDA drive, busy, write strobes and the register file against a model.
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int NREG = 16;
  localparam int Q    = 8;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              scl_m = 1'b1;
  logic              sda_m = 1'b1;
  logic              sda_oe;
  logic              wr_strobe;
  logic              busy;
  logic [8*NREG-1:0] regs_flat;
  logic [3:0]        wr_ptr;
  wire               sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile #(
    .I2C_ADDR    (7'h70),
    .NUM_REGS    (NREG),
    .SYNC_STAGES (2),
    .RESET_VAL   (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .wr_ptr    (wr_ptr),
    .busy      (busy)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;
  logic exp_oe = 1'b0;
  logic exp_busy = 1'b0;
  int   exp_wq[$];
  int   exp_w;

  logic [7:0] m_regs [NREG];
  int         m_ptr;

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (sda_oe !== exp_oe) begin
        n_bad++;
        $display("FAIL sda_oe t=%0t got %b want %b", $time, sda_oe, exp_oe);
      end
      n_vec++;
      if (busy !== exp_busy) begin
        n_bad++;
        $display("FAIL busy t=%0t got %b want %b", $time, busy, exp_busy);
      end
    end
    if (rst_n && wr_strobe === 1'b1) begin
      n_vec++;
      if (exp_wq.size() == 0) begin
        n_bad++;
        $display("FAIL wr_strobe t=%0t got pulse ptr=%0d want none", $time, wr_ptr);
      end else begin
        exp_w = exp_wq.pop_front();
        if (wr_ptr !== 4'(exp_w)) begin
          n_bad++;
          $display("FAIL wr_ptr t=%0t got %0d want %0d", $time, wr_ptr, exp_w);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NREG; k++) begin
      n_vec++;
      if (regs_flat[8*k +: 8] !== m_regs[k]) begin
        n_bad++;
        $display("FAIL %s reg[%0d] got %02h want %02h", tag, k, regs_flat[8*k +: 8], m_regs[k]);
      end
    end
  endtask

  task automatic end_checks(input string tag);
    chk({tag, " busy_idle"}, 32'(busy), 32'd0);
    chk({tag, " sda_oe_idle"}, 32'(sda_oe), 32'd0);
    chk({tag, " strobes_pending"}, 32'(exp_wq.size()), 32'd0);
    check_regs(tag);
  endtask

  // One SCL clock: low phase drives the master bit, high phase opens the check window
  task automatic scl_bit(input logic mbit, input logic eoe, input logic ebusy, output logic seen);
    repeat (Q) @(negedge clk);
    sda_m    = mbit;
    exp_oe   = eoe;
    exp_busy = ebusy;
    repeat (Q) @(negedge clk);
    scl_m = 1'b1;
    repeat (6) @(negedge clk);
    chk_en = 1'b1;
    repeat (8) @(negedge clk);
    chk_en = 1'b0;
    seen = sda_line;
    repeat (2) @(negedge clk);
    scl_m = 1'b0;
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      repeat (Q) @(negedge clk);
      sda_m = 1'b1;
      repeat (Q) @(negedge clk);
      scl_m = 1'b1;
      repeat (Q) @(negedge clk);
    end
    sda_m = 1'b0;
    repeat (Q) @(negedge clk);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    repeat (Q) @(negedge clk);
    sda_m = 1'b0;
    repeat (Q) @(negedge clk);
    scl_m = 1'b1;
    repeat (Q) @(negedge clk);
    sda_m = 1'b1;
    repeat (2*Q) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic busy_pre, input logic busy_post,
                           input logic ack_exp, input string name);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      scl_bit(b[i], 1'b0, (i == 0) ? busy_post : busy_pre, seen);
    end
    scl_bit(1'b1, ack_exp, busy_post, seen);
    chk({name, " ack_line"}, 32'(seen), 32'(!ack_exp));
  endtask

  task automatic recv_byte(input logic [7:0] want, input logic mack, output logic [7:0] got);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      scl_bit(1'b1, ~want[i], 1'b1, seen);
      got[i] = seen;
    end
    scl_bit(mack, 1'b0, ~mack, seen);
  endtask

  task automatic tx_write(input logic [7:0] sub, input logic [7:0] d0, input logic [7:0] d1, input int nd);
    logic       ok;
    logic [7:0] d;
    ok = (int'(sub) < NREG);
    bus_start();
    send_byte(8'hE0, 1'b0, 1'b1, 1'b1, "wr addr");
    send_byte(sub, 1'b1, ok, ok, "wr sub");
    if (ok) m_ptr = int'(sub);
    for (int k = 0; k < nd; k++) begin
      d = (k == 0) ? d0 : d1;
      if (ok) begin
        exp_wq.push_back(m_ptr);
        m_regs[m_ptr] = d;
        m_ptr = (m_ptr + 1) % NREG;
      end
      send_byte(d, ok, ok, ok, "wr data");
    end
    bus_stop();
    end_checks("write");
    $display("tx write sub=%02h bytes=%0d accepted=%0d", sub, nd, ok);
  endtask

  task automatic tx_read(input logic [7:0] sub, output logic [7:0] r0, output logic [7:0] r1);
    logic [7:0] want;
    bus_start();
    send_byte(8'hE0, 1'b0, 1'b1, 1'b1, "rd addr_w");
    send_byte(sub, 1'b1, 1'b1, 1'b1, "rd sub");
    m_ptr = int'(sub);
    bus_start();
    send_byte(8'hE1, 1'b1, 1'b1, 1'b1, "rd addr_r");
    want = m_regs[m_ptr];
    m_ptr = (m_ptr + 1) % NREG;
    recv_byte(want, 1'b0, r0);
    chk("rd byte0", 32'(r0), 32'(want));
    want = m_regs[m_ptr];
    m_ptr = (m_ptr + 1) % NREG;
    recv_byte(want, 1'b1, r1);
    chk("rd byte1", 32'(r1), 32'(want));
    chk("rd sda_oe_after_nak", 32'(sda_oe), 32'd0);
    bus_stop();
    end_checks("read");
    $display("tx read sub=%02h data=%02h %02h", sub, r0, r1);
  endtask

  task automatic tx_foreign(input logic [7:0] addr);
    bus_start();
    send_byte(addr, 1'b0, 1'b0, 1'b0, "foreign addr");
    send_byte(8'h0A, 1'b0, 1'b0, 1'b0, "foreign sub");
    send_byte(8'h12, 1'b0, 1'b0, 1'b0, "foreign data");
    bus_stop();
    end_checks("foreign");
    $display("tx foreign addr=%02h ignored", addr);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1;
    logic       seen;

    for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
    m_ptr = 0;

    repeat (5) @(negedge clk);
    chk("rst sda_oe", 32'(sda_oe), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst wr_ptr", 32'(wr_ptr), 32'd0);
    check_regs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("tx reset released");

    tx_write(8'h0A, 8'h55, 8'h1F, 2);
    chk("pin reg10", 32'(regs_flat[87:80]), 32'h55);
    chk("pin reg11", 32'(regs_flat[95:88]), 32'h1F);

    tx_read(8'h0A, r0, r1);
    chk("pin read0", 32'(r0), 32'h55);
    chk("pin read1", 32'(r1), 32'h1F);

    tx_write(8'h0F, 8'hAA, 8'hBB, 2);
    chk("pin reg15", 32'(regs_flat[127:120]), 32'hAA);
    chk("pin reg0", 32'(regs_flat[7:0]), 32'hBB);

    tx_read(8'h0F, r0, r1);
    chk("pin wrapread0", 32'(r0), 32'hAA);
    chk("pin wrapread1", 32'(r1), 32'hBB);

    tx_foreign(8'hC0);
    tx_foreign(8'h00);

    tx_write(8'h10, 8'h77, 8'h00, 1);

    // STOP after half a data byte must not write
    bus_start();
    send_byte(8'hE0, 1'b0, 1'b1, 1'b1, "part addr");
    send_byte(8'h03, 1'b1, 1'b1, 1'b1, "part sub");
    m_ptr = 3;
    for (int i = 0; i < 4; i++) scl_bit(1'b1, 1'b0, 1'b1, seen);
    bus_stop();
    end_checks("partial");
    chk("pin reg3_partial", 32'(regs_flat[31:24]), 32'h00);
    $display("tx partial byte discarded");

    tx_write(8'h03, 8'h3C, 8'h00, 1);
    chk("pin reg3", 32'(regs_flat[31:24]), 32'h3C);

    // Reset asserted while the target is holding the sub-address ACK
    bus_start();
    send_byte(8'hE0, 1'b0, 1'b1, 1'b1, "rst addr");
    for (int i = 7; i >= 0; i--) scl_bit(i == 0 || i == 2, 1'b0, 1'b1, seen);
    repeat (Q) @(negedge clk);
    sda_m = 1'b1;
    repeat (Q) @(negedge clk);
    scl_m = 1'b1;
    repeat (6) @(negedge clk);
    chk("oe before rst", 32'(sda_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("oe async rst", 32'(sda_oe), 32'd0);
    chk("busy async rst", 32'(busy), 32'd0);
    for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
    m_ptr = 0;
    check_regs("async_rst");
    chk("pin reg10_rst", 32'(regs_flat[87:80]), 32'h00);
    repeat (4) @(negedge clk);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("tx reset during ack");

    tx_write(8'h02, 8'h99, 8'h00, 1);
    chk("pin reg2", 32'(regs_flat[23:16]), 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
